dsp_mode_ctrl: RTL and testbench
================================

# dsp_mode_ctrl

Sequencer that applies DSP-mode changes to the DSP datapath safely. It sits between the CSR file's write of the DSP mode register (CSR 0x800) and the DSP unit. On a mode-change request it stalls new DSP issue, drains in-flight DSP operations, switches the mode, and waits a settle window before releasing issue. It is the only driver of the mode seen by the DSP datapath.

## Interface
- Reset is synchronous and active-high, on a single clock.

Parameters:
- CNT_W, 4, width of the in-flight operation counter.
- DRAIN_MAX, 16, maximum number of DRAIN cycles before the request is aborted.
- SETTLE_CYC, 2, number of SETTLE cycles after the mode is applied (must be ≥1).

Ports (name  direction  width  meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  mode-change request; raised by the CSR write to 0x800
- req_mode  in  2  requested mode
- req_ready  out  1  controller can accept a request
- dsp_issue  in  1  a DSP op enters the DSP unit this cycle
- dsp_retire  in  1  a DSP op leaves the DSP unit this cycle
- issue_stall  out  1  the issue stage must not issue DSP ops
- dsp_mode  out  2  active mode driven to the DSP datapath
- inflight  out  CNT_W  number of DSP ops currently in flight
- switch_done  out  1  one-cycle pulse when a request completes
- timeout_err  out  1  one-cycle pulse when a request is aborted

## Operation
- **Reset values:** state IDLE; dsp_mode=0; inflight=0; all pulse outputs and issue_stall are 0.
- **States:** IDLE, DRAIN, SWITCH, SETTLE.
- **IDLE**
  - req_ready=1. A request is accepted when req_valid&&req_ready is high at a clock edge; req_mode is then latched into pending_mode.
  - If req_mode==dsp_mode, stay in IDLE, pulse switch_done on the next cycle, and do not stall.
  - Otherwise go to DRAIN and clear the drain counter.
- **DRAIN**
  - If inflight==0, go to SWITCH.
  - Otherwise increment the drain counter. Once DRAIN_MAX cycles have elapsed with inflight≠0, return to IDLE, pulse timeout_err, and leave dsp_mode unchanged.
- **SWITCH:** lasts one cycle; dsp_mode<=pending_mode, then go to SETTLE.
- **SETTLE:** lasts SETTLE_CYC cycles; then go to IDLE and pulse switch_done.
- **issue_stall:** asserted when state≠IDLE or when inflight==2^CNT_W−1 (counter full).
- **In-flight counter**
  - Next value is inflight + (issue counted) − (retire counted).
  - Issue and retire in the same cycle leave the count unchanged.
  - dsp_issue is not counted while issue_stall=1. This is a protocol violation by the issue stage.
  - dsp_retire is not counted when inflight==0. The counter never wraps.
  - An issue in the same cycle a request is accepted is counted, because the stall only begins the following cycle.
- **req_ready** is 0 in every state other than IDLE. Requests arriving then are not accepted, and the requester holds req_valid.
- **Reset during any state** returns the block to reset values on the next edge. A pending request is lost.

## Timing
- Outputs are decoded from registered state and counters. There are no combinational paths from inputs to outputs.
- For a request accepted at edge T with inflight=0:
  - DRAIN in cycle T+1, with issue_stall high from T+1.
  - SWITCH in T+2.
  - New dsp_mode visible from T+3.
  - SETTLE from T+3 to T+2+SETTLE_CYC.
  - IDLE with switch_done in T+3+SETTLE_CYC. With defaults this is T+5, and issue_stall deasserts in that same cycle.
- Each extra DRAIN cycle adds one cycle of latency.
- Timeout: with defaults, timeout_err pulses in T+1+DRAIN_MAX and the block is in IDLE in that cycle.
- A same-mode request accepted at T pulses switch_done in T+1.
- switch_done and timeout_err are mutually exclusive and each lasts exactly one cycle.

## Structure
- Shared package dsp_pkg holds:
  - typedef dsp_mode_t (2-bit logic);
  - enum ctrl_state_t {IDLE, DRAIN, SWITCH, SETTLE};
  - localparam DSPMODE_CSR=12'h800, shared with the CSR file.
- One sub-module, dsp_inflight_cnt, is the saturating up/down counter with the full and zero flags.
- The FSM, the drain/settle counter and pending_mode stay in the top module.

## Test plan
- **Reset and basic switch:** after reset, check dsp_mode=0, inflight=0, issue_stall=0. Request mode 2 at T with no traffic → dsp_mode=2 from T+3, switch_done at T+5, issue_stall high only in T+1..T+4.
- **Drain:** issue 3 ops before the request, then retire one every 2 cycles → stay in DRAIN until inflight=0, then switch. dsp_mode must not change while inflight>0.
- **Timeout:** issue 1 op and never retire it; request mode 1 → timeout_err at T+17, dsp_mode stays 0, req_ready=1 again at T+17.
- **Same mode:** with dsp_mode=2, request 2 → switch_done at T+1, issue_stall never asserted.
- **Counter boundaries:**
  - simultaneous issue+retire → inflight unchanged;
  - retire at 0 → stays 0;
  - 15 issues → issue_stall high and a further issue is ignored;
  - issue in the accept cycle → counted.
- **Reset mid-DRAIN with inflight=4** → next cycle IDLE, dsp_mode=0, inflight=0, no pulse outputs.

Source files
------------

// File: rtl/dsp_pkg.sv
// Types and constants shared by the DSP mode sequencer and the CSR file.
package dsp_pkg;

    typedef logic [1:0] dsp_mode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        SWITCH = 2'd2,
        SETTLE = 2'd3
    } ctrl_state_t;

    // CSR address of the DSP mode register; the CSR file decodes writes here into req_valid.
    localparam logic [11:0] DSPMODE_CSR = 12'h800;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dsp_mode_ctrl_if.sv
// Request, issue/retire and status signals between the CSR/issue side and the mode sequencer.
interface dsp_mode_ctrl_if #(
    parameter int CNT_W = 4
);
    import dsp_pkg::*;

    logic             req_valid;
    dsp_mode_t        req_mode;
    logic             req_ready;
    logic             dsp_issue;
    logic             dsp_retire;
    logic             issue_stall;
    dsp_mode_t        dsp_mode;
    logic [CNT_W-1:0] inflight;
    logic             switch_done;
    logic             timeout_err;

    modport master (
        output req_valid, req_mode, dsp_issue, dsp_retire,
        input  req_ready, issue_stall, dsp_mode, inflight, switch_done, timeout_err
    );

    modport slave (
        input  req_valid, req_mode, dsp_issue, dsp_retire,
        output req_ready, issue_stall, dsp_mode, inflight, switch_done, timeout_err
    );

endinterface

// File: rtl/dsp_inflight_cnt.sv
// Saturating up/down count of DSP ops in flight; never wraps in either direction.
module dsp_inflight_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic do_inc;
    logic do_dec;

    assign full   = (count == '1);
    assign empty  = (count == '0);
    assign do_inc = inc && !full;
    assign do_dec = dec && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (do_inc && !do_dec) begin
            count <= count + 1'b1;
        end else if (do_dec && !do_inc) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/dsp_mode_ctrl.sv
// DSP mode-change sequencer: stall issue, drain in-flight ops, apply the mode, settle, release.
//
// state  | meaning
// IDLE   | issue open, accepting mode-change requests
// DRAIN  | issue stalled, waiting for in-flight ops to retire (bounded)
// SWITCH | one cycle, new mode registered onto dsp_mode
// SETTLE | issue still stalled while the datapath settles on the new mode
module dsp_mode_ctrl
    import dsp_pkg::*;
#(
    parameter int CNT_W      = 4,
    parameter int DRAIN_MAX  = 16,
    parameter int SETTLE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    dsp_mode_ctrl_if.slave    bus
);

    localparam int TMR_W = $clog2(max_int(DRAIN_MAX, SETTLE_CYC) + 1);
    localparam logic [TMR_W-1:0] DRAIN_LOAD  = TMR_W'(DRAIN_MAX - 1);
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYC - 1);

    ctrl_state_t      state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    dsp_mode_t        pending_q, pending_d;
    dsp_mode_t        mode_q, mode_d;
    logic             done_q, done_d;
    logic             tout_q, tout_d;

    logic [CNT_W-1:0] cnt;
    logic             cnt_full;
    logic             cnt_empty;
    logic             stall;
    logic             accept;

    assign stall  = (state_q != IDLE) || cnt_full;
    assign accept = bus.req_valid && (state_q == IDLE);

    // An issue arriving while stalled is a protocol violation and is dropped.
    dsp_inflight_cnt #(
        .CNT_W (CNT_W)
    ) u_inflight (
        .clk   (clk),
        .rst   (rst),
        .inc   (bus.dsp_issue && !stall),
        .dec   (bus.dsp_retire),
        .count (cnt),
        .full  (cnt_full),
        .empty (cnt_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            tmr_q     <= '0;
            pending_q <= '0;
            mode_q    <= '0;
            done_q    <= 1'b0;
            tout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            pending_q <= pending_d;
            mode_q    <= mode_d;
            done_q    <= done_d;
            tout_q    <= tout_d;
        end
    end

    // One down-counter serves as drain budget and settle window; terminal count is zero.
    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        pending_d = pending_q;
        mode_d    = mode_q;
        done_d    = 1'b0;
        tout_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    pending_d = bus.req_mode;
                    if (bus.req_mode == mode_q) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = DRAIN;
                        tmr_d   = DRAIN_LOAD;
                    end
                end
            end
            DRAIN: begin
                if (cnt_empty) begin
                    state_d = SWITCH;
                end else if (tmr_q == '0) begin
                    state_d = IDLE;
                    tout_d  = 1'b1;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            SWITCH: begin
                mode_d  = pending_q;
                tmr_d   = SETTLE_LOAD;
                state_d = SETTLE;
            end
            SETTLE: begin
                if (tmr_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready   = (state_q == IDLE);
    assign bus.issue_stall = stall;
    assign bus.dsp_mode    = mode_q;
    assign bus.inflight    = cnt;
    assign bus.switch_done = done_q;
    assign bus.timeout_err = tout_q;

endmodule

// File: tb/tb_dsp_mode_ctrl.sv
// Directed scenarios with timing from the cycle rules, then random traffic against a timeline model.
module tb_dsp_mode_ctrl;

    localparam int CNT_W      = 4;
    localparam int DRAIN_MAX  = 16;
    localparam int SETTLE_CYC = 2;
    localparam int FULL_CNT   = 15;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    dsp_mode_ctrl_if #(.CNT_W(CNT_W)) bus ();

    dsp_mode_ctrl #(
        .CNT_W      (CNT_W),
        .DRAIN_MAX  (DRAIN_MAX),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired: got=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_mode = 2'd0;
        bus.dsp_issue = 1'b0; bus.dsp_retire = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        checks++; if (bus.dsp_mode !== 2'd0) begin failures++; $display("FAIL reset dsp_mode got=%0d exp=0", bus.dsp_mode); end
        checks++; if (bus.inflight !== 4'd0) begin failures++; $display("FAIL reset inflight got=%0d exp=0", bus.inflight); end
        checks++; if (bus.issue_stall !== 1'b0) begin failures++; $display("FAIL reset issue_stall got=%b exp=0", bus.issue_stall); end
        checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL reset req_ready got=%b exp=1", bus.req_ready); end
        checks++; if (bus.switch_done !== 1'b0) begin failures++; $display("FAIL reset switch_done got=%b exp=0", bus.switch_done); end
        checks++; if (bus.timeout_err !== 1'b0) begin failures++; $display("FAIL reset timeout_err got=%b exp=0", bus.timeout_err); end
    endtask

    task automatic test_basic_switch();
        bus.req_mode = 2'd2; bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            checks++; if (bus.issue_stall !== (k <= 4)) begin failures++; $display("FAIL basic stall k=%0d got=%b exp=%b", k, bus.issue_stall, (k <= 4)); end
            checks++; if (bus.dsp_mode !== ((k >= 3) ? 2'd2 : 2'd0)) begin failures++; $display("FAIL basic dsp_mode k=%0d got=%0d", k, bus.dsp_mode); end
            checks++; if (bus.switch_done !== (k == 5)) begin failures++; $display("FAIL basic switch_done k=%0d got=%b exp=%b", k, bus.switch_done, (k == 5)); end
            checks++; if (bus.req_ready !== (k >= 5)) begin failures++; $display("FAIL basic req_ready k=%0d got=%b exp=%b", k, bus.req_ready, (k >= 5)); end
            step();
        end
    endtask

    task automatic test_drain();
        int e_cnt;
        bus.dsp_issue = 1'b1;
        for (int i = 0; i < 3; i++) step();
        bus.dsp_issue = 1'b0;
        bus.req_mode = 2'd1; bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            bus.dsp_retire = (k == 2 || k == 4 || k == 6);
            e_cnt = (k <= 2) ? 3 : (k <= 4) ? 2 : (k <= 6) ? 1 : 0;
            checks++; if (bus.inflight !== 4'(e_cnt)) begin failures++; $display("FAIL drain inflight k=%0d got=%0d exp=%0d", k, bus.inflight, e_cnt); end
            checks++; if (bus.dsp_mode !== ((k >= 9) ? 2'd1 : 2'd2)) begin failures++; $display("FAIL drain dsp_mode k=%0d got=%0d", k, bus.dsp_mode); end
            checks++; if (bus.switch_done !== (k == 11)) begin failures++; $display("FAIL drain switch_done k=%0d got=%b", k, bus.switch_done); end
            checks++; if (bus.issue_stall !== (k <= 10)) begin failures++; $display("FAIL drain stall k=%0d got=%b", k, bus.issue_stall); end
            step();
        end
        bus.dsp_retire = 1'b0;
    endtask

    task automatic test_timeout();
        rst = 1'b1; step(); rst = 1'b0;
        bus.dsp_issue = 1'b1; step(); bus.dsp_issue = 1'b0;
        bus.req_mode = 2'd1; bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            checks++; if (bus.timeout_err !== (k == DRAIN_MAX + 1)) begin failures++; $display("FAIL timeout pulse k=%0d got=%b", k, bus.timeout_err); end
            checks++; if (bus.req_ready !== (k >= DRAIN_MAX + 1)) begin failures++; $display("FAIL timeout req_ready k=%0d got=%b", k, bus.req_ready); end
            checks++; if (bus.dsp_mode !== 2'd0) begin failures++; $display("FAIL timeout dsp_mode k=%0d got=%0d exp=0", k, bus.dsp_mode); end
            checks++; if (bus.switch_done !== 1'b0) begin failures++; $display("FAIL timeout switch_done k=%0d got=%b exp=0", k, bus.switch_done); end
            step();
        end
        bus.dsp_retire = 1'b1; step(); bus.dsp_retire = 1'b0;
        checks++; if (bus.inflight !== 4'd0) begin failures++; $display("FAIL timeout cleanup inflight got=%0d exp=0", bus.inflight); end
    endtask

    task automatic test_same_mode();
        bit seen;
        seen = 1'b0;
        bus.req_mode = 2'd2; bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (bus.switch_done === 1'b1) seen = 1'b1;
            step();
        end
        checks++; if (!seen) begin failures++; $display("FAIL same_mode setup switch_done got=none exp=pulse"); end
        checks++; if (bus.dsp_mode !== 2'd2) begin failures++; $display("FAIL same_mode setup dsp_mode got=%0d exp=2", bus.dsp_mode); end
        bus.req_mode = 2'd2; bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            checks++; if (bus.switch_done !== (k == 1)) begin failures++; $display("FAIL same_mode switch_done k=%0d got=%b", k, bus.switch_done); end
            checks++; if (bus.issue_stall !== 1'b0) begin failures++; $display("FAIL same_mode stall k=%0d got=%b exp=0", k, bus.issue_stall); end
            checks++; if (bus.dsp_mode !== 2'd2) begin failures++; $display("FAIL same_mode dsp_mode k=%0d got=%0d exp=2", k, bus.dsp_mode); end
            step();
        end
    endtask

    task automatic test_counter_bounds();
        bus.dsp_retire = 1'b1; step(); bus.dsp_retire = 1'b0;
        checks++; if (bus.inflight !== 4'd0) begin failures++; $display("FAIL cnt retire_at_zero got=%0d exp=0", bus.inflight); end
        bus.dsp_issue = 1'b1; step();
        bus.dsp_retire = 1'b1; step(); bus.dsp_retire = 1'b0;
        checks++; if (bus.inflight !== 4'd1) begin failures++; $display("FAIL cnt issue_and_retire got=%0d exp=1", bus.inflight); end
        for (int i = 0; i < 14; i++) step();
        checks++; if (bus.inflight !== 4'(FULL_CNT)) begin failures++; $display("FAIL cnt full got=%0d exp=15", bus.inflight); end
        checks++; if (bus.issue_stall !== 1'b1) begin failures++; $display("FAIL cnt full stall got=%b exp=1", bus.issue_stall); end
        step();
        checks++; if (bus.inflight !== 4'(FULL_CNT)) begin failures++; $display("FAIL cnt issue_at_full got=%0d exp=15", bus.inflight); end
        bus.dsp_retire = 1'b1; step(); bus.dsp_issue = 1'b0;
        checks++; if (bus.inflight !== 4'd14) begin failures++; $display("FAIL cnt issue_retire_at_full got=%0d exp=14", bus.inflight); end
        for (int i = 0; i < 14; i++) step();
        bus.dsp_retire = 1'b0;
        checks++; if (bus.inflight !== 4'd0) begin failures++; $display("FAIL cnt drain_to_zero got=%0d exp=0", bus.inflight); end
        bus.req_mode = 2'd3; bus.req_valid = 1'b1; bus.dsp_issue = 1'b1;
        step();
        bus.req_valid = 1'b0; bus.dsp_issue = 1'b0;
        checks++; if (bus.inflight !== 4'd1) begin failures++; $display("FAIL cnt accept_cycle_issue got=%0d exp=1", bus.inflight); end
        bus.dsp_retire = 1'b1; step(); bus.dsp_retire = 1'b0;
        for (int k = 2; k <= 7; k++) begin
            checks++; if (bus.dsp_mode !== ((k >= 4) ? 2'd3 : 2'd2)) begin failures++; $display("FAIL cnt accept_switch dsp_mode k=%0d got=%0d", k, bus.dsp_mode); end
            checks++; if (bus.switch_done !== (k == 6)) begin failures++; $display("FAIL cnt accept_switch done k=%0d got=%b", k, bus.switch_done); end
            step();
        end
    endtask

    task automatic test_reset_mid_drain();
        bus.dsp_issue = 1'b1;
        for (int i = 0; i < 4; i++) step();
        bus.dsp_issue = 1'b0;
        bus.req_mode = 2'd0; bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
        step();
        checks++; if (bus.issue_stall !== 1'b1 || bus.inflight !== 4'd4) begin failures++; $display("FAIL mid_drain pre stall=%b inflight=%0d exp stall=1 inflight=4", bus.issue_stall, bus.inflight); end
        rst = 1'b1; step(); rst = 1'b0;
        checks++; if (bus.dsp_mode !== 2'd0) begin failures++; $display("FAIL mid_drain dsp_mode got=%0d exp=0", bus.dsp_mode); end
        checks++; if (bus.inflight !== 4'd0) begin failures++; $display("FAIL mid_drain inflight got=%0d exp=0", bus.inflight); end
        checks++; if (bus.issue_stall !== 1'b0 || bus.req_ready !== 1'b1) begin failures++; $display("FAIL mid_drain idle stall=%b ready=%b exp 0/1", bus.issue_stall, bus.req_ready); end
        checks++; if (bus.switch_done !== 1'b0 || bus.timeout_err !== 1'b0) begin failures++; $display("FAIL mid_drain pulses done=%b tout=%b exp 0/0", bus.switch_done, bus.timeout_err); end
        step();
        checks++; if (bus.switch_done !== 1'b0 || bus.timeout_err !== 1'b0 || bus.dsp_mode !== 2'd0) begin failures++; $display("FAIL mid_drain after done=%b tout=%b mode=%0d exp 0/0/0", bus.switch_done, bus.timeout_err, bus.dsp_mode); end
    endtask

    // Model: a request's phases are located by cycle number (accept, mode-apply, release).
    task automatic test_random();
        int       m_cnt, m_acc, m_apply, n_cnt, rpct;
        bit       m_busy, m_done, m_to, n_done, n_to, m_stall;
        bit       r_rst, r_val, r_iss, r_ret;
        logic [1:0] m_mode, m_pend, r_mode;
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.dsp_issue = 1'b0; bus.dsp_retire = 1'b0;
        step();
        rst = 1'b0;
        m_cnt = 0; m_mode = 2'd0; m_pend = 2'd0; m_busy = 1'b0; m_acc = 0; m_apply = -1;
        m_done = 1'b0; m_to = 1'b0; rpct = 50;
        for (int n = 0; n < 3000; n++) begin
            m_stall = m_busy || (m_cnt == FULL_CNT);
            checks++; if (bus.inflight !== 4'(m_cnt) || bus.dsp_mode !== m_mode) begin failures++; $display("FAIL rand n=%0d inflight=%0d mode=%0d exp %0d/%0d", n, bus.inflight, bus.dsp_mode, m_cnt, m_mode); end
            checks++; if (bus.issue_stall !== m_stall || bus.req_ready !== !m_busy) begin failures++; $display("FAIL rand n=%0d stall=%b ready=%b exp %b/%b", n, bus.issue_stall, bus.req_ready, m_stall, !m_busy); end
            checks++; if (bus.switch_done !== m_done || bus.timeout_err !== m_to) begin failures++; $display("FAIL rand n=%0d done=%b tout=%b exp %b/%b", n, bus.switch_done, bus.timeout_err, m_done, m_to); end
            if (n % 200 == 0) rpct = $urandom_range(10, 90);
            r_rst  = ($urandom_range(0, 399) == 0);
            r_val  = ($urandom_range(0, 5) == 0);
            r_mode = 2'($urandom_range(0, 3));
            r_iss  = ($urandom_range(0, 2) == 0);
            r_ret  = ($urandom_range(0, 99) < rpct);
            rst = r_rst; bus.req_valid = r_val; bus.req_mode = r_mode;
            bus.dsp_issue = r_iss; bus.dsp_retire = r_ret;
            if (r_rst) begin
                m_cnt = 0; m_mode = 2'd0; m_busy = 1'b0; m_apply = -1; m_done = 1'b0; m_to = 1'b0;
            end else begin
                n_cnt  = m_cnt + ((r_iss && !m_stall) ? 1 : 0) - ((r_ret && m_cnt != 0) ? 1 : 0);
                n_done = 1'b0; n_to = 1'b0;
                if (!m_busy) begin
                    if (r_val) begin
                        if (r_mode == m_mode) n_done = 1'b1;
                        else begin m_busy = 1'b1; m_pend = r_mode; m_acc = n; m_apply = -1; end
                    end
                end else if (m_apply < 0) begin
                    if (m_cnt == 0) m_apply = n + 2;
                    else if (n - m_acc == DRAIN_MAX) begin m_busy = 1'b0; n_to = 1'b1; end
                end else begin
                    if (n + 1 == m_apply) m_mode = m_pend;
                    if (n + 1 == m_apply + SETTLE_CYC) begin m_busy = 1'b0; n_done = 1'b1; end
                end
                m_cnt = n_cnt; m_done = n_done; m_to = n_to;
            end
            step();
        end
        rst = 1'b0; bus.req_valid = 1'b0; bus.dsp_issue = 1'b0; bus.dsp_retire = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_basic_switch();
        test_drain();
        test_timeout();
        test_same_mode();
        test_counter_bounds();
        test_reset_mid_drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
